// File: rtl/simon_pkg.sv
// Shared definitions for the Simon game sequencer: colour and comparator
// encodings, controller state enum and the LFSR step function.
package simon_pkg;

  localparam int unsigned COLOUR_W = 2;
  localparam int unsigned LFSR_W   = 8;

  localparam logic [COLOUR_W-1:0] RED    = 2'd0;
  localparam logic [COLOUR_W-1:0] GREEN  = 2'd1;
  localparam logic [COLOUR_W-1:0] BLUE   = 2'd2;
  localparam logic [COLOUR_W-1:0] YELLOW = 2'd3;

  localparam logic [1:0] CMP_NONE  = 2'b00;
  localparam logic [1:0] CMP_MATCH = 2'b01;
  localparam logic [1:0] CMP_MISS  = 2'b10;

  typedef enum logic [3:0] {
    IDLE,
    EXTEND,
    SHOW_ON,
    SHOW_OFF,
    WAIT_IN,
    ISSUE,
    EVAL,
    WIN,
    LOSE
  } state_t;

  // Fibonacci step for x^8+x^6+x^5+x^4+1: shift left, feedback into bit 0.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 8-bit pseudo-random source for new sequence colours.
// Ports: clk, reset (async, active-high, loads SEED), lfsr (current state).
module simon_lfsr
  import simon_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              reset,
  output logic [LFSR_W-1:0] lfsr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= lfsr_step(lfsr);
  end

endmodule

// File: rtl/simon_controller.sv
// Simon game sequencer: grows a random colour sequence, plays it on the LEDs,
// then feeds each player press with its expected colour to the comparator
// and advances, wins or loses based on the comparator result.
// Ports: clk/reset; start, btn_valid/btn_colour from the player; cmp_out from
// the comparator; cmp_enable/cmp_in/cmp_expected to the comparator;
// show_valid/show_colour to the LEDs; level, busy, game_over, win status.
module simon_controller
  import simon_pkg::*;
#(
  parameter int unsigned       MAX_LEN     = 16,
  parameter int unsigned       SHOW_CYCLES = 4,
  parameter int unsigned       GAP_CYCLES  = 2,
  parameter logic [LFSR_W-1:0] SEED        = 8'hA5,
  localparam int unsigned      LVL_W       = $clog2(MAX_LEN + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                btn_valid,
  input  logic [COLOUR_W-1:0] btn_colour,
  input  logic [1:0]          cmp_out,
  output logic                cmp_enable,
  output logic [COLOUR_W-1:0] cmp_in,
  output logic [COLOUR_W-1:0] cmp_expected,
  output logic                show_valid,
  output logic [COLOUR_W-1:0] show_colour,
  output logic [LVL_W-1:0]    level,
  output logic                busy,
  output logic                game_over,
  output logic                win
);

  localparam int unsigned IDX_W   = $clog2(MAX_LEN);
  localparam int unsigned CNT_MAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t               state, state_n;
  logic [LVL_W-1:0]     level_n;
  logic [IDX_W-1:0]     idx, idx_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic [COLOUR_W-1:0]  cmp_in_n, cmp_exp_n;
  logic [COLOUR_W-1:0]  show_col_n;
  logic                 mem_we;
  logic                 last;
  logic [COLOUR_W-1:0]  mem [MAX_LEN];
  logic [LFSR_W-1:0]    lfsr;
  logic                 lfsr_unused;

  simon_lfsr #(.SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  // Only the two low LFSR bits pick a colour.
  assign lfsr_unused = ^lfsr[LFSR_W-1:COLOUR_W];

  // Current index is the final entry of the sequence.
  assign last = ((LVL_W'(idx) + LVL_W'(1)) == level);

  // Sequence store; contents are meaningless until written by EXTEND.
  always_ff @(posedge clk) begin
    if (mem_we) mem[IDX_W'(level)] <= lfsr[COLOUR_W-1:0];
  end

  // Next-state and next-data logic.
  always_comb begin
    state_n   = state;
    level_n   = level;
    idx_n     = idx;
    cnt_n     = cnt;
    cmp_in_n  = cmp_in;
    cmp_exp_n = cmp_expected;
    mem_we    = 1'b0;
    case (state)
      IDLE, WIN, LOSE: begin
        if (start) begin
          level_n = '0;
          idx_n   = '0;
          cnt_n   = '0;
          state_n = EXTEND;
        end
      end
      EXTEND: begin
        mem_we  = 1'b1;
        level_n = level + LVL_W'(1);
        idx_n   = '0;
        cnt_n   = '0;
        state_n = SHOW_ON;
      end
      SHOW_ON: begin
        if (cnt == CNT_W'(SHOW_CYCLES - 1)) begin
          cnt_n   = '0;
          state_n = SHOW_OFF;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      SHOW_OFF: begin
        if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
          cnt_n = '0;
          if (last) begin
            idx_n   = '0;
            state_n = WAIT_IN;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = SHOW_ON;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      WAIT_IN: begin
        if (btn_valid) begin
          cmp_in_n  = btn_colour;
          cmp_exp_n = mem[idx];
          state_n   = ISSUE;
        end
      end
      ISSUE: state_n = EVAL;
      EVAL: begin
        // Anything other than a match, including no result at all, loses.
        if (cmp_out == CMP_MATCH) begin
          if (!last) begin
            idx_n   = idx + IDX_W'(1);
            state_n = WAIT_IN;
          end else if (level == LVL_W'(MAX_LEN)) begin
            state_n = WIN;
          end else begin
            state_n = EXTEND;
          end
        end else begin
          state_n = LOSE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // LED colour for the coming cycle; forwards the colour being written in
  // EXTEND since the store has not captured it yet.
  always_comb begin
    show_col_n = '0;
    if (state_n == SHOW_ON) begin
      if (mem_we && (IDX_W'(level) == idx_n)) show_col_n = lfsr[COLOUR_W-1:0];
      else                                     show_col_n = mem[idx_n];
    end
  end

  // State, counters and registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      level        <= '0;
      idx          <= '0;
      cnt          <= '0;
      cmp_in       <= '0;
      cmp_expected <= '0;
      cmp_enable   <= 1'b0;
      show_valid   <= 1'b0;
      show_colour  <= '0;
      busy         <= 1'b0;
      game_over    <= 1'b0;
      win          <= 1'b0;
    end else begin
      state        <= state_n;
      level        <= level_n;
      idx          <= idx_n;
      cnt          <= cnt_n;
      cmp_in       <= cmp_in_n;
      cmp_expected <= cmp_exp_n;
      cmp_enable   <= (state_n == ISSUE);
      show_valid   <= (state_n == SHOW_ON);
      show_colour  <= show_col_n;
      busy         <= !((state_n == IDLE) || (state_n == WIN) || (state_n == LOSE));
      game_over    <= (state_n == WIN) || (state_n == LOSE);
      win          <= (state_n == WIN);
    end
  end

endmodule

// File: tb/tb_simon_controller.sv
// Self-checking bench for simon_controller with a registered comparator model,
// a reference LFSR and scoreboards for LED playback and comparator requests.
module tb_simon_controller;
  import simon_pkg::*;

  localparam int unsigned MAX_LEN     = 2;
  localparam int unsigned SHOW_CYCLES = 4;
  localparam int unsigned GAP_CYCLES  = 2;
  localparam logic [7:0]  SEED        = 8'hA5;
  localparam int unsigned LVL_W       = $clog2(MAX_LEN + 1);
  localparam int          N0          = 3;

  typedef struct packed {
    logic [1:0] pin;
    logic [1:0] pexp;
  } press_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             btn_valid = 1'b0;
  logic [1:0]       btn_colour = 2'd0;
  logic [1:0]       cmp_out;
  logic             cmp_enable;
  logic [1:0]       cmp_in;
  logic [1:0]       cmp_expected;
  logic             show_valid;
  logic [1:0]       show_colour;
  logic [LVL_W-1:0] level;
  logic             busy;
  logic             game_over;
  logic             win;

  int checks = 0;
  int errors = 0;

  logic [1:0] seq[$];
  logic [1:0] exp_show[$];
  press_t     exp_cmp[$];
  logic [1:0] first_col;
  logic       cmp_drop = 1'b0;
  logic [7:0] m_lfsr;

  simon_controller #(
    .MAX_LEN(MAX_LEN), .SHOW_CYCLES(SHOW_CYCLES), .GAP_CYCLES(GAP_CYCLES), .SEED(SEED)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .btn_valid(btn_valid),
    .btn_colour(btn_colour), .cmp_out(cmp_out), .cmp_enable(cmp_enable),
    .cmp_in(cmp_in), .cmp_expected(cmp_expected), .show_valid(show_valid),
    .show_colour(show_colour), .level(level), .busy(busy),
    .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  // Reference LFSR, x^8+x^6+x^5+x^4+1, shifting left with feedback into bit 0.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= SEED;
    else       m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  end

  // Registered comparator; cmp_drop models a comparator that never answers.
  always @(posedge clk or posedge reset) begin
    if (reset)                       cmp_out <= CMP_NONE;
    else if (cmp_enable && !cmp_drop) cmp_out <= (cmp_in == cmp_expected) ? CMP_MATCH : CMP_MISS;
    else                             cmp_out <= CMP_NONE;
  end

  // Monitor: pops playback and comparator expectations as the DUT produces them.
  bit         in_show = 0;
  bit         gap_armed = 0;
  int         lit_cnt = 0;
  int         gap_cnt = 0;
  logic [1:0] cur_col = 2'd0;

  always @(negedge clk) begin
    if (reset) begin
      exp_show.delete();
      in_show   = 0;
      gap_armed = 0;
    end else begin
      if (show_valid) begin
        if (!in_show) begin
          if (gap_armed) begin
            checks++;
            if (gap_cnt != GAP_CYCLES) begin
              errors++;
              $display("FAIL gap_length: got %0d dark cycles, want %0d", gap_cnt, GAP_CYCLES);
            end
          end
          gap_armed = 0;
          checks++;
          if (exp_show.size() == 0) begin
            errors++;
            $display("FAIL unexpected_show: colour %0d lit with nothing expected", show_colour);
          end else begin
            cur_col = exp_show.pop_front();
          end
          in_show = 1;
          lit_cnt = 0;
        end
        lit_cnt++;
        checks++;
        if (show_colour !== cur_col) begin
          errors++;
          $display("FAIL show_colour: got %0d, want %0d", show_colour, cur_col);
        end
      end else begin
        if (in_show) begin
          checks++;
          if (lit_cnt != SHOW_CYCLES) begin
            errors++;
            $display("FAIL show_length: got %0d lit cycles, want %0d", lit_cnt, SHOW_CYCLES);
          end
          in_show   = 0;
          gap_armed = 1;
          gap_cnt   = 0;
        end
        if (gap_armed) gap_cnt++;
        checks++;
        if (show_colour !== 2'd0) begin
          errors++;
          $display("FAIL dark_colour: got %0d, want 0", show_colour);
        end
      end
      if (cmp_enable) begin
        checks++;
        if (exp_cmp.size() == 0) begin
          errors++;
          $display("FAIL unexpected_cmp_enable: cmp_in=%0d cmp_expected=%0d", cmp_in, cmp_expected);
        end else begin
          press_t p;
          p = exp_cmp.pop_front();
          if (cmp_in !== p.pin || cmp_expected !== p.pexp) begin
            errors++;
            $display("FAIL cmp_payload: got in=%0d exp=%0d, want in=%0d exp=%0d",
                     cmp_in, cmp_expected, p.pin, p.pexp);
          end
        end
      end
      if (cmp_enable || !busy) gap_armed = 0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Returns at the first dark cycle after n lit runs have ended.
  task automatic wait_dark_after(input int n, output bit ok);
    int falls;
    bit prev;
    falls = 0;
    prev  = show_valid;
    for (int i = 0; i < 300; i++) begin
      cyc();
      if (prev && !show_valid) falls++;
      prev = show_valid;
      if (falls == n) break;
    end
    ok = (falls == n);
  endtask

  task automatic test_reset();
    cyc();
    cyc();
    checks++;
    if ({cmp_enable, cmp_in, cmp_expected, show_valid, show_colour, level, busy, game_over, win} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: en=%0b in=%0d exp=%0d sv=%0b sc=%0d lvl=%0d busy=%0b go=%0b win=%0b, want all 0",
               cmp_enable, cmp_in, cmp_expected, show_valid, show_colour, level, busy, game_over, win);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_round();
    bit ok;
    repeat (N0) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    // EXTEND
    checks++;
    if ({busy, show_valid, level} !== {1'b1, 1'b0, LVL_W'(0)}) begin
      errors++;
      $display("FAIL first_extend: busy=%0b sv=%0b level=%0d, want 1 0 0", busy, show_valid, level);
    end
    first_col = m_lfsr[1:0];
    seq.delete();
    seq.push_back(first_col);
    exp_show.push_back(first_col);
    cyc();
    checks++;
    if ({show_valid, level} !== {1'b1, LVL_W'(1)}) begin
      errors++;
      $display("FAIL first_show: sv=%0b level=%0d, want 1 1", show_valid, level);
    end
    wait_dark_after(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL first_playback_timeout: got no end of playback, want 1 lit run");
    end
    cyc();
    // Last gap cycle: a press here must be ignored.
    btn_valid  = 1'b1;
    btn_colour = first_col;
    cyc();
    btn_valid = 1'b0;
    checks++;
    if ({cmp_enable, busy, show_valid} !== 3'b010) begin
      errors++;
      $display("FAIL gap_press_ignored: en=%0b busy=%0b sv=%0b, want 0 1 0", cmp_enable, busy, show_valid);
    end
  endtask

  task automatic test_correct_press();
    press_t p;
    btn_valid  = 1'b1;
    btn_colour = seq[0];
    p.pin  = seq[0];
    p.pexp = seq[0];
    exp_cmp.push_back(p);
    cyc();
    btn_valid = 1'b0;
    checks++;
    if (cmp_enable !== 1'b1) begin
      errors++;
      $display("FAIL press_enable_t1: got %0b, want 1", cmp_enable);
    end
    cyc();
    checks++;
    if (cmp_enable !== 1'b0) begin
      errors++;
      $display("FAIL press_enable_t2: got %0b, want 0", cmp_enable);
    end
    cyc();
    checks++;
    if ({busy, show_valid, level} !== {1'b1, 1'b0, LVL_W'(1)}) begin
      errors++;
      $display("FAIL round2_extend: busy=%0b sv=%0b level=%0d, want 1 0 1", busy, show_valid, level);
    end
    seq.push_back(m_lfsr[1:0]);
    foreach (seq[i]) exp_show.push_back(seq[i]);
    cyc();
    checks++;
    if ({show_valid, level} !== {1'b1, LVL_W'(2)}) begin
      errors++;
      $display("FAIL round2_show: sv=%0b level=%0d, want 1 2", show_valid, level);
    end
  endtask

  task automatic test_ignored_inputs();
    bit ok;
    btn_valid  = 1'b1;
    btn_colour = seq[0] + 2'd1;
    cyc();
    btn_valid = 1'b0;
    checks++;
    if ({cmp_enable, show_valid, level} !== {1'b0, 1'b1, LVL_W'(2)}) begin
      errors++;
      $display("FAIL show_press_ignored: en=%0b sv=%0b level=%0d, want 0 1 2", cmp_enable, show_valid, level);
    end
    wait_dark_after(2, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL round2_playback_timeout: got no end of playback, want 2 lit runs");
    end
    repeat (GAP_CYCLES) cyc();
    // WAIT_IN: start is ignored while busy
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if ({busy, show_valid, cmp_enable, level} !== {1'b1, 1'b0, 1'b0, LVL_W'(2)}) begin
      errors++;
      $display("FAIL busy_start_ignored: busy=%0b sv=%0b en=%0b level=%0d, want 1 0 0 2",
               busy, show_valid, cmp_enable, level);
    end
    cyc();
    checks++;
    if ({show_valid, level} !== {1'b0, LVL_W'(2)}) begin
      errors++;
      $display("FAIL busy_start_no_replay: sv=%0b level=%0d, want 0 2", show_valid, level);
    end
  endtask

  task automatic test_win();
    press_t p;
    for (int k = 0; k < 2; k++) begin
      btn_valid  = 1'b1;
      btn_colour = seq[k];
      p.pin  = seq[k];
      p.pexp = seq[k];
      exp_cmp.push_back(p);
      cyc();
      btn_valid = 1'b0;
      checks++;
      if (cmp_enable !== 1'b1) begin
        errors++;
        $display("FAIL win_press_enable: press %0d got %0b, want 1", k, cmp_enable);
      end
      cyc();
      cyc();
    end
    checks++;
    if ({win, game_over, busy, level} !== {1'b1, 1'b1, 1'b0, LVL_W'(2)}) begin
      errors++;
      $display("FAIL win_state: win=%0b go=%0b busy=%0b level=%0d, want 1 1 0 2", win, game_over, busy, level);
    end
    btn_valid  = 1'b1;
    btn_colour = seq[0];
    cyc();
    btn_valid = 1'b0;
    checks++;
    if ({cmp_enable, win} !== 2'b01) begin
      errors++;
      $display("FAIL win_press_ignored: en=%0b win=%0b, want 0 1", cmp_enable, win);
    end
  endtask

  task automatic test_loss_restart();
    bit ok;
    press_t p;
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if ({busy, game_over, win, level} !== {1'b1, 1'b0, 1'b0, LVL_W'(0)}) begin
      errors++;
      $display("FAIL restart_from_win: busy=%0b go=%0b win=%0b level=%0d, want 1 0 0 0", busy, game_over, win, level);
    end
    seq.delete();
    seq.push_back(m_lfsr[1:0]);
    exp_show.push_back(seq[0]);
    wait_dark_after(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL loss_playback_timeout: got no end of playback, want 1 lit run");
    end
    repeat (GAP_CYCLES) cyc();
    btn_valid  = 1'b1;
    btn_colour = seq[0] + 2'd1;
    p.pin  = seq[0] + 2'd1;
    p.pexp = seq[0];
    exp_cmp.push_back(p);
    cyc();
    btn_valid = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({game_over, win, busy, level} !== {1'b1, 1'b0, 1'b0, LVL_W'(1)}) begin
      errors++;
      $display("FAIL lose_state: go=%0b win=%0b busy=%0b level=%0d, want 1 0 0 1", game_over, win, busy, level);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++;
    if ({busy, game_over, show_valid, level} !== {1'b1, 1'b0, 1'b0, LVL_W'(0)}) begin
      errors++;
      $display("FAIL restart_extend: busy=%0b go=%0b sv=%0b level=%0d, want 1 0 0 0", busy, game_over, show_valid, level);
    end
    exp_show.push_back(m_lfsr[1:0]);
    cyc();
    checks++;
    if ({show_valid, busy, level} !== {1'b1, 1'b1, LVL_W'(1)}) begin
      errors++;
      $display("FAIL restart_show: sv=%0b busy=%0b level=%0d, want 1 1 1", show_valid, busy, level);
    end
  endtask

  task automatic test_reset_mid_game();
    cyc();
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({cmp_enable, cmp_in, cmp_expected, show_valid, show_colour, level, busy, game_over, win} !== '0) begin
      errors++;
      $display("FAIL async_reset: sv=%0b sc=%0d lvl=%0d busy=%0b in=%0d exp=%0d, want all 0",
               show_valid, show_colour, level, busy, cmp_in, cmp_expected);
    end
    cyc();
    cyc();
    reset = 1'b0;
    repeat (N0) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    seq.delete();
    seq.push_back(first_col);
    exp_show.push_back(first_col);
    cyc();
    checks++;
    if ({show_valid, show_colour} !== {1'b1, first_col}) begin
      errors++;
      $display("FAIL reseed_colour: sv=%0b colour=%0d, want 1 %0d", show_valid, show_colour, first_col);
    end
  endtask

  task automatic test_missing_result();
    bit ok;
    press_t p;
    wait_dark_after(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL reseed_playback_timeout: got no end of playback, want 1 lit run");
    end
    repeat (GAP_CYCLES) cyc();
    cmp_drop   = 1'b1;
    btn_valid  = 1'b1;
    btn_colour = seq[0];
    p.pin  = seq[0];
    p.pexp = seq[0];
    exp_cmp.push_back(p);
    cyc();
    btn_valid = 1'b0;
    cyc();
    cyc();
    checks++;
    if ({game_over, win, busy, level} !== {1'b1, 1'b0, 1'b0, LVL_W'(1)}) begin
      errors++;
      $display("FAIL no_result_loses: go=%0b win=%0b busy=%0b level=%0d, want 1 0 0 1", game_over, win, busy, level);
    end
    cmp_drop = 1'b0;
    cyc();
    checks++;
    if (exp_show.size() != 0 || exp_cmp.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: show=%0d cmp=%0d pending, want 0 0", exp_show.size(), exp_cmp.size());
    end
  endtask

  initial begin
    test_reset();
    test_first_round();
    test_correct_press();
    test_ignored_inputs();
    test_win();
    test_loss_restart();
    test_reset_mid_game();
    test_missing_result();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/simon_controller.md
# simon_controller

Game sequencer for the Simon datapath. It grows a pseudo-random colour sequence one colour per round and plays it back on the LED outputs. It then collects player button presses and feeds each press plus the expected colour to the colour comparator, one press at a time. From the comparator result it decides whether to continue, advance a round, win or lose.

## Interface
- MAX_LEN, 16: maximum sequence length (rounds to win); must be ≥ 2.
- SHOW_CYCLES, 4: cycles each colour is lit during playback; must be ≥ 1.
- GAP_CYCLES, 2: dark cycles after each lit colour; must be ≥ 1.
- SEED, 8'hA5: LFSR reset value; must be non-zero.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  one-cycle pulse; begins a new game.
- btn_valid  in  1  one-cycle strobe; player pressed a button.
- btn_colour  in  2  colour pressed; valid with btn_valid.
- cmp_out  in  2  comparator result: 00 none, 01 match, 10 mismatch.
- cmp_enable  out  1  comparator enable; one-cycle pulse per press.
- cmp_in  out  2  player colour to the comparator.
- cmp_expected  out  2  expected colour to the comparator.
- show_valid  out  1  LED lit.
- show_colour  out  2  LED colour; 0 when show_valid=0.
- level  out  $clog2(MAX_LEN+1)  current sequence length.
- busy  out  1  game in progress.
- game_over  out  1  game ended (win or lose).
- win  out  1  game ended by completing MAX_LEN rounds.

## Operation
- **LFSR:** 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1. It steps every cycle from reset. New colour = lfsr[1:0] sampled in EXTEND.
- **Sequence store:** MAX_LEN×2-bit register array. Index counter idx has width $clog2(MAX_LEN).
- **IDLE:** all outputs 0. start → level←0, go to EXTEND.
- **EXTEND (1 cycle):** mem[level]←lfsr[1:0]; level←level+1; idx←0; go to SHOW_ON.
- **SHOW_ON:** show_valid=1, show_colour=mem[idx] for exactly SHOW_CYCLES cycles, then go to SHOW_OFF.
- **SHOW_OFF:** dark for exactly GAP_CYCLES cycles. Then:
  - if idx==level-1: idx←0, go to WAIT_IN;
  - else: idx←idx+1, go to SHOW_ON.
- **WAIT_IN:** waits indefinitely. On btn_valid: latch cmp_in←btn_colour and cmp_expected←mem[idx], go to ISSUE.
- **ISSUE (1 cycle):** cmp_enable=1. cmp_in and cmp_expected hold until the next press.
- **EVAL (1 cycle):** sample cmp_out.
  - 01 with idx<level-1: idx←idx+1, go to WAIT_IN.
  - 01 with idx==level-1 and level<MAX_LEN: go to EXTEND.
  - 01 with idx==level-1 and level==MAX_LEN: go to WIN.
  - 10 or 00: go to LOSE. A missing result counts as a loss.
- **WIN:** game_over=1, win=1. **LOSE:** game_over=1, win=0. Both hold until start, which restarts exactly as from IDLE. level holds its final value while in WIN or LOSE.
- busy=1 in every state except IDLE, WIN and LOSE.
- **Ignored inputs:**
  - start while busy=1.
  - btn_valid outside WAIT_IN (including during SHOW and ISSUE/EVAL).
  - btn_colour when btn_valid=0.
- **Reset (including mid-game):** state→IDLE, level/idx/counters←0, lfsr←SEED, every output←0. Sequence store contents are don't-care.

## Timing
- All outputs are registered, decoded from the registered state plus registered data.
- Press latency: btn_valid high in cycle T (state WAIT_IN) → cmp_enable high in T+1 → cmp_out sampled in T+2 → next state entered in T+3.
- Comparator contract: it registers its result, so the result is visible the cycle after its enable.
- Round turnaround: last correct press EVAL → EXTEND (1 cycle) → first SHOW_ON cycle.
- One playback of level L takes L×(SHOW_CYCLES+GAP_CYCLES) cycles.
- start during WIN/LOSE: EXTEND is the next cycle.

## Structure
- **Package simon_pkg holds:**
  - colour constants RED=0, GREEN=1, BLUE=2, YELLOW=3;
  - comparator result constants CMP_NONE=00, CMP_MATCH=01, CMP_MISS=10;
  - the controller state enum (IDLE, EXTEND, SHOW_ON, SHOW_OFF, WAIT_IN, ISSUE, EVAL, WIN, LOSE).
- **Sub-module simon_lfsr:** SEED parameter, clk/reset, 8-bit state output.
- The sequence store, counters and FSM stay in simon_controller.

## Test plan
- **First round playback.** MAX_LEN=2, SHOW_CYCLES=4, GAP_CYCLES=2; start → EXTEND for 1 cycle, level=1, show_valid high exactly 4 cycles with show_colour=stored colour, then 2 dark cycles, then WAIT_IN with busy=1.
- **Correct press, next round.** Correct btn_valid at T with comparator model returning 01 → cmp_enable high only at T+1 with cmp_expected=mem[0]; EXTEND at T+3; level=2; two colours replayed, mem[0] first.
- **Win.** Complete both presses of round 2 correctly → win=1, game_over=1, busy=0, level=2 at EVAL+1; later btn_valid produces no cmp_enable.
- **Loss then restart.** Wrong press, comparator returns 10 → game_over=1, win=0, level held. Then start → level=1, busy=1, next cycle in EXTEND.
- **Ignored inputs.** btn_valid during SHOW_ON and start during WAIT_IN → no cmp_enable, no state change, level unchanged.
- **Reset mid-game.** reset asserted mid-SHOW_ON → all outputs 0 asynchronously. After release, start produces the same first colour as a start issued the same number of cycles after the initial reset (LFSR reseeded to SEED).
